// File: rtl/reg_bank_3r1w.sv
// Purpose : 16 x 16-bit register file with two decode read ports, one
//           destination-register read port, and one write-back write port.
// Latency : reads are combinational; a write lands on the next rising edge.
//           With BYPASS=1 the write data is forwarded to matching read ports
//           in the same cycle.
// Backpressure: none; a write is accepted on every edge where sinal=1.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous reset, active-low; clears every register
//   sinal     - write enable from the write-back stage
//   entrada1  - read address, port 1
//   entrada2  - read address, port 2
//   entrada3  - write address, also the read address for port 3
//   dado      - write data
//   saida1..3 - read data for ports 1..3
module reg_bank_3r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sinal,
  input  logic [ADDR_W-1:0] entrada1,
  input  logic [ADDR_W-1:0] entrada2,
  input  logic [ADDR_W-1:0] entrada3,
  input  logic [DATA_W-1:0] dado,
  output logic [DATA_W-1:0] saida1,
  output logic [DATA_W-1:0] saida2,
  output logic [DATA_W-1:0] saida3
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];

  // A write that will commit on this edge. Reset blocks both the write and
  // the forwarding path, so outputs never show data that is about to be
  // discarded.
  logic w_fwd;
  assign w_fwd = BYP_EN && sinal && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (sinal) begin
      r_regs[entrada3] <= dado;
    end
  end

  // Port 3 is addressed by the write address itself, so it forwards on
  // every active write without an address compare.
  always_comb begin
    saida1 = r_regs[entrada1];
    saida2 = r_regs[entrada2];
    saida3 = r_regs[entrada3];
    if (w_fwd) begin
      if (entrada1 == entrada3) saida1 = dado;
      if (entrada2 == entrada3) saida2 = dado;
      saida3 = dado;
    end
  end

endmodule

// File: tb/tb_reg_bank_3r1w.sv
// Purpose : directed plus randomized checks of reg_bank_3r1w against an
//           array-based reference model of the register file.
// Latency : outputs sampled 1-2 time units after inputs settle / after edges.
// Backpressure: not applicable.
module tb_reg_bank_3r1w;

  logic        clk;
  logic        reset;
  logic        sinal;
  logic [3:0]  entrada1;
  logic [3:0]  entrada2;
  logic [3:0]  entrada3;
  logic [15:0] dado;
  logic [15:0] saida1;
  logic [15:0] saida2;
  logic [15:0] saida3;

  int checks;
  int errors;

  // Reference contents of R0..R15.
  logic [15:0] m [16];

  reg_bank_3r1w #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .sinal    (sinal),
    .entrada1 (entrada1),
    .entrada2 (entrada2),
    .entrada3 (entrada3),
    .dado     (dado),
    .saida1   (saida1),
    .saida2   (saida2),
    .saida3   (saida3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value: a write that commits this edge (not in reset) is
  // seen early on any port reading its address; otherwise stored contents.
  function automatic logic [15:0] model_rd(input logic [3:0] a);
    if (reset && sinal && a == entrada3) return dado;
    return m[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".s1"}, saida1, model_rd(entrada1));
    check({tag, ".s2"}, saida2, model_rd(entrada2));
    check({tag, ".s3"}, saida3, model_rd(entrada3));
  endtask

  // Advance one rising edge; the model commits using the inputs present now.
  task automatic tick();
    if (!reset) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    end else if (sinal) begin
      m[entrada3] = dado;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    reset = 1'b1; sinal = 1'b1; entrada3 = a; dado = d;
    tick();
    sinal = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    reset = 1'b0; sinal = 1'b0;
    entrada1 = '0; entrada2 = '0; entrada3 = '0; dado = '0;
    @(negedge clk);
    tick();

    // 1: reset clears a previously written register and all others.
    write_reg(4'd5, 16'h1234);
    entrada1 = 4'd5; #1;
    check("pre_reset_r5", saida1, 16'h1234);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      entrada1 = 4'(i); entrada2 = 4'(i); entrada3 = 4'(i);
      #1;
      check("reset_s1", saida1, 16'h0000);
      check("reset_s2", saida2, 16'h0000);
      check("reset_s3", saida3, 16'h0000);
    end

    // 2: basic write then read.
    write_reg(4'd3, 16'h00AB);
    entrada1 = 4'd3; entrada2 = 4'd0; entrada3 = 4'd3; #1;
    check("basic_s1", saida1, 16'h00AB);
    check("basic_s2", saida2, 16'h0000);
    check("basic_s3", saida3, 16'h00AB);

    // 3: write enable low leaves R7 untouched.
    sinal = 1'b0; entrada3 = 4'd7; dado = 16'hFFFF;
    tick();
    entrada1 = 4'd7; #1;
    check("wen_off_s1", saida1, 16'h0000);
    check("wen_off_s3", saida3, 16'h0000);

    // 4: same-cycle forwarding on all three ports.
    write_reg(4'd2, 16'h0010);
    sinal = 1'b1; entrada3 = 4'd2; dado = 16'h0055;
    entrada1 = 4'd2; entrada2 = 4'd2; #1;
    check("byp_s1", saida1, 16'h0055);
    check("byp_s2", saida2, 16'h0055);
    check("byp_s3", saida3, 16'h0055);
    tick();
    sinal = 1'b0; #1;
    check("byp_after_s1", saida1, 16'h0055);
    check("byp_after_s2", saida2, 16'h0055);
    check("byp_after_s3", saida3, 16'h0055);

    // 5: reset wins over a simultaneous write and blocks forwarding.
    reset = 1'b0; sinal = 1'b1; entrada3 = 4'd9; dado = 16'hBEEF; #1;
    check("rst_nobyp_s3", saida3, 16'h0000);
    tick();
    reset = 1'b1; sinal = 1'b0; entrada1 = 4'd9; entrada2 = 4'd2; #1;
    check("rst_vs_wr_r9", saida1, 16'h0000);
    check("rst_vs_wr_r2", saida2, 16'h0000);

    // 6: sweep every register, then overwrite only R15.
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      entrada1 = 4'(i); #1;
      check("sweep", saida1, 16'h1000 + 16'(i));
    end
    write_reg(4'd15, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      entrada1 = 4'(i); #1;
      check("sweep_r15", saida1, (i == 15) ? 16'hFFFF : 16'h1000 + 16'(i));
    end

    // Randomized traffic against the model, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 19) != 0);
      sinal    = $urandom_range(0, 1) == 1;
      entrada3 = 4'($urandom_range(0, 15));
      entrada1 = ($urandom_range(0, 3) == 0) ? entrada3 : 4'($urandom_range(0, 15));
      entrada2 = ($urandom_range(0, 3) == 0) ? entrada1 : 4'($urandom_range(0, 15));
      dado     = 16'($urandom);
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
